fetch_controller: RTL and testbench
===================================

Name: fetch_controller

Overview:
- Instruction-fetch sequencer between the 24-bit program ROM and the decode/execute stage.
- Owns the program counter (PC) and drives the ROM read address.
- Absorbs the ROM's one-cycle registered read latency and presents each instruction to decode with a valid/ready handshake.
- Applies jump/branch redirects and CALL/RET control flow through an internal return-address stack.

Parameters:
- ADDR_WIDTH, 8: width of PC, ROM address and return addresses.
- ROM_MAX, 8'h1A: highest legal program address; ROM_MIN is fixed at 0.
- STACK_DEPTH, 8: number of return-address stack entries (1..16).

Ports:
- clock  input  1  50 MHz system clock.
- reset_s2  input  1  synchronized reset, synchronous, active-high.
- rom_address  output  ADDR_WIDTH  read address to program ROM; equals PC register.
- rom_data  input  24  ROM output; valid one clock after rom_address changes.
- instr  output  24  instruction presented to decode.
- instr_pc  output  ADDR_WIDTH  address of instr.
- instr_valid  output  1  instr/instr_pc valid.
- instr_ready  input  1  decode accepts instr this cycle.
- redirect  input  1  taken JMP/branch; sampled on accept only.
- call  input  1  CALL; sampled on accept only.
- ret  input  1  RET; sampled on accept only.
- target_addr  input  ADDR_WIDTH  destination for redirect/call.
- fault  output  1  sticky fault indication.
- fault_code  output  2  0 none, 1 stack overflow, 2 stack underflow, 3 PC out of range.
- fetch_count  output  16  accepted-instruction counter (see Optional Feature).

Behaviour:
- Reset: on any clock edge with reset_s2=1, including mid-operation:
  - PC=0, stack empty (sp=0), state FETCH.
  - instr=0, instr_pc=0, instr_valid=0, fault=0, fault_code=0, fetch_count=0.
- States:
  - FETCH: rom_address=PC. Next edge: instr<=rom_data, instr_pc<=PC, instr_valid<=1, go HOLD.
  - HOLD: instr_valid=1. instr and instr_pc are stable while instr_ready=0, for unbounded stall. On instr_valid & instr_ready (accept), compute next PC and go FETCH, or go FAULT.
  - FAULT: instr_valid=0, fault=1, fault_code held, PC frozen. Exit only via reset_s2.
- Throughput: one instruction per 2 clocks minimum; first instr_valid asserts in the 2nd cycle after reset release.
- Next PC on accept, by priority ret > call > redirect > sequential; lower-priority inputs are ignored when a higher one is set:
  - ret: if sp=0, go FAULT with code 2. Otherwise PC<=stack[sp-1], sp<=sp-1.
  - call: if sp=STACK_DEPTH, go FAULT with code 1. Otherwise stack[sp]<=instr_pc+1, sp<=sp+1, PC<=target_addr.
  - redirect: PC<=target_addr.
  - none: PC<=instr_pc+1, computed in ADDR_WIDTH+1 bits with no wrap.
- Range check: a new PC > ROM_MAX (from any source, including 8'hFF+1) goes FAULT with code 3 instead of FETCH. The ROM is never addressed out of range.
- Control inputs are don't-care outside accept cycles.
- Stack contents are not cleared on reset; only sp resets.

Optional Feature:
- Macro FETCH_COUNT_EN.
- Defined: fetch_count increments by 1 on every accept, saturates at 16'hFFFF, and clears on reset.
- Undefined: no counter logic; fetch_count is tied to 0.

Test Plan:
- Reset release, ROM[0]=24'hA10D00, ready=1 -> rom_address=0; instr_valid=1 in cycle 2 with instr=24'hA10D00, instr_pc=0; next fetch address 1.
- Stall: instr_ready=0 for 5 cycles at PC 3 -> instr and instr_pc=3 stable, rom_address unchanged; accept in cycle 6 -> fetch address 4.
- CALL at instr_pc 0x00, target 0x0D, then RET at 0x11 -> fetch 0x0D, then 0x01; sp returns to 0. Set ret+call+redirect together -> ret wins.
- RET with empty stack -> fault=1, fault_code=2, instr_valid=0 until reset_s2; after reset, normal fetch resumes from 0.
- STACK_DEPTH=8, nine nested CALLs -> the ninth gives fault_code=1.
- Sequential from ROM_MAX=0x1A, or redirect to 0x1B -> fault_code=3, and rom_address never exceeds 0x1A.
- With FETCH_COUNT_EN: 10 accepts -> fetch_count=10. Without it: fetch_count=0.

Source files
------------

// File: rtl/fetch_controller.sv
// fetch_controller
// Instruction-fetch sequencer between the program ROM and decode/execute.
// Owns the program counter, absorbs the ROM read latency, hands each
// instruction to decode with a valid/ready handshake, and resolves
// RET/CALL/JMP control flow through a small return-address stack.
//
// Ports:
//   clock        system clock
//   reset_s2     synchronized reset, synchronous, active-high
//   rom_address  ROM read address (the PC register)
//   rom_data     ROM output, valid one clock after rom_address changes
//   instr        instruction presented to decode
//   instr_pc     address of instr
//   instr_valid  instr/instr_pc valid
//   instr_ready  decode accepts instr this cycle
//   redirect     taken JMP/branch (sampled on accept)
//   call         CALL (sampled on accept)
//   ret          RET (sampled on accept)
//   target_addr  destination for redirect/call
//   fault        sticky fault indication
//   fault_code   0 none, 1 stack overflow, 2 stack underflow, 3 PC out of range
//   fetch_count  accepted-instruction counter
//
// Optional feature macro: FETCH_COUNT_EN
//   defined   -> fetch_count counts accepts, saturating at 16'hFFFF
//   undefined -> fetch_count is tied to 0

module fetch_controller #(
    parameter int                    ADDR_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] ROM_MAX     = 'h1A,
    parameter int                    STACK_DEPTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_s2,
    output logic [ADDR_WIDTH-1:0] rom_address,
    input  logic [23:0]           rom_data,
    output logic [23:0]           instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  redirect,
    input  logic                  call,
    input  logic                  ret,
    input  logic [ADDR_WIDTH-1:0] target_addr,
    output logic                  fault,
    output logic [1:0]            fault_code,
    output logic [15:0]           fetch_count
);

    // sp must be able to hold the value STACK_DEPTH (full stack).
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    // Stack storage is rounded up to a power of two so every sp-derived
    // index is in range, including the wrapped index read when sp is 0.
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_FETCH,
        S_HOLD,
        S_FAULT
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic [SP_W-1:0]       sp;
    logic [ADDR_WIDTH-1:0] stack [1 << IDX_W];

    logic                  accept;
    logic [ADDR_WIDTH:0]   seq_pc;
    logic [ADDR_WIDTH:0]   new_pc;
    logic                  load_pc;
    logic                  commit;
    logic                  push;
    logic                  pop;
    logic [1:0]            code_next;
    logic [IDX_W-1:0]      push_idx;
    logic [IDX_W-1:0]      pop_idx;

    assign rom_address = pc;
    assign accept      = (state == S_HOLD) && instr_ready;
    // One extra bit so the increment past the top address is seen, not wrapped.
    assign seq_pc      = {1'b0, instr_pc} + (ADDR_WIDTH + 1)'(1);
    assign push_idx    = sp[IDX_W-1:0];
    assign pop_idx     = IDX_W'(sp - SP_W'(1));

    // State register.
    always_ff @(posedge clock) begin
        if (reset_s2) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs. On accept the control inputs are
    // resolved by priority ret > call > redirect > sequential; any new PC,
    // whatever its source, must pass the range check before it is used.
    always_comb begin
        state_next  = state;
        new_pc      = {1'b0, pc};
        load_pc     = 1'b0;
        commit      = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        code_next   = 2'd0;
        instr_valid = 1'b0;
        fault       = 1'b0;
        case (state)
            S_FETCH: begin
                state_next = S_HOLD;
            end
            S_HOLD: begin
                instr_valid = 1'b1;
                if (accept) begin
                    if (ret) begin
                        if (sp == '0) begin
                            state_next = S_FAULT;
                            code_next  = 2'd2;
                        end else begin
                            new_pc  = {1'b0, stack[pop_idx]};
                            pop     = 1'b1;
                            load_pc = 1'b1;
                        end
                    end else if (call) begin
                        if (sp == SP_W'(STACK_DEPTH)) begin
                            state_next = S_FAULT;
                            code_next  = 2'd1;
                        end else begin
                            new_pc  = {1'b0, target_addr};
                            push    = 1'b1;
                            load_pc = 1'b1;
                        end
                    end else if (redirect) begin
                        new_pc  = {1'b0, target_addr};
                        load_pc = 1'b1;
                    end else begin
                        new_pc  = seq_pc;
                        load_pc = 1'b1;
                    end

                    if (load_pc) begin
                        if (new_pc > {1'b0, ROM_MAX}) begin
                            state_next = S_FAULT;
                            code_next  = 2'd3;
                        end else begin
                            state_next = S_FETCH;
                            commit     = 1'b1;
                        end
                    end
                end
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // Datapath: instruction capture, PC, stack pointer and fault code.
    // A faulting accept leaves PC and sp untouched, so the ROM keeps
    // seeing the last in-range address.
    always_ff @(posedge clock) begin
        if (reset_s2) begin
            pc         <= '0;
            sp         <= '0;
            instr      <= '0;
            instr_pc   <= '0;
            fault_code <= 2'd0;
        end else begin
            if (state == S_FETCH) begin
                instr    <= rom_data;
                instr_pc <= pc;
            end
            if (commit) begin
                pc <= new_pc[ADDR_WIDTH-1:0];
                if (push) begin
                    sp <= sp + SP_W'(1);
                end else if (pop) begin
                    sp <= sp - SP_W'(1);
                end
            end
            if ((state == S_HOLD) && (state_next == S_FAULT)) begin
                fault_code <= code_next;
            end
        end
    end

    // Return-address storage keeps its contents across reset; only sp clears.
    always_ff @(posedge clock) begin
        if (commit && push) begin
            stack[push_idx] <= seq_pc[ADDR_WIDTH-1:0];
        end
    end

`ifdef FETCH_COUNT_EN
    logic [15:0] count;

    // Counts every accept, including one that ends in a fault.
    always_ff @(posedge clock) begin
        if (reset_s2) begin
            count <= '0;
        end else if (accept && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

    assign fetch_count = count;
`else
    assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller
// Self-checking bench for fetch_controller. A combinational ROM image is
// filled with random words; a transaction-level model (integer PC, a queue
// as the return stack, a fault flag) predicts each presented instruction,
// the fetch address after each accept, fault codes and the accept counter.
// Directed scenarios run first, then randomized control flow with random
// stalls and occasional mid-operation resets.
// Honours FETCH_COUNT_EN the same way as the design.

module tb_fetch_controller;

    localparam int          AW      = 8;
    localparam int          ROM_MAX = 'h1A;
    localparam int          DEPTH   = 8;

    logic          clock = 1'b0;
    logic          reset_s2 = 1'b1;
    logic [AW-1:0] rom_address;
    logic [23:0]   rom_data;
    logic [23:0]   instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic          redirect = 1'b0;
    logic          call = 1'b0;
    logic          ret = 1'b0;
    logic [AW-1:0] target_addr = '0;
    logic          fault;
    logic [1:0]    fault_code;
    logic [15:0]   fetch_count;

    logic [23:0]   mem [0:255];

    int            checks = 0;
    int            errors = 0;
    int            exp_pc;
    int            ret_stack[$];
    int            exp_count;
    bit            exp_fault;
    int            exp_code;
    int            max_addr = 0;

    fetch_controller #(
        .ADDR_WIDTH (AW),
        .ROM_MAX    (8'h1A),
        .STACK_DEPTH(DEPTH)
    ) dut (
        .clock      (clock),
        .reset_s2   (reset_s2),
        .rom_address(rom_address),
        .rom_data   (rom_data),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .redirect   (redirect),
        .call       (call),
        .ret        (ret),
        .target_addr(target_addr),
        .fault      (fault),
        .fault_code (fault_code),
        .fetch_count(fetch_count)
    );

    always #10 clock = ~clock;

    // ROM data settles within the cycle after the address changes.
    assign rom_data = mem[rom_address];

    always @(negedge clock) begin
        if (int'(rom_address) > max_addr) max_addr = int'(rom_address);
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    function automatic int expectedCount();
`ifdef FETCH_COUNT_EN
        return exp_count;
`else
        return 0;
`endif
    endfunction

    task automatic scrambleControls();
        ret         = 1'($urandom_range(0, 1));
        call        = 1'($urandom_range(0, 1));
        redirect    = 1'($urandom_range(0, 1));
        target_addr = 8'($urandom);
    endtask

    task automatic doReset();
        reset_s2    = 1'b1;
        instr_ready = 1'b0;
        scrambleControls();
        repeat (2) @(negedge clock);
        checkOutput("rst_valid", instr_valid, 0);
        checkOutput("rst_fault", fault, 0);
        checkOutput("rst_code", fault_code, 0);
        checkOutput("rst_instr", instr, 0);
        checkOutput("rst_instr_pc", instr_pc, 0);
        checkOutput("rst_rom_addr", rom_address, 0);
        checkOutput("rst_count", fetch_count, 0);
        reset_s2  = 1'b0;
        exp_pc    = 0;
        ret_stack.delete();
        exp_count = 0;
        exp_fault = 1'b0;
        exp_code  = 0;
    endtask

    // One fetched instruction: wait for it, check it, optionally stall,
    // accept it with the given controls, then check the outcome.
    task automatic applyStimulus(input bit r, input bit c, input bit j, input logic [AW-1:0] tgt, input int stall);
        int n;
        int new_pc;
        int code;
        n = 0;
        while (!instr_valid && n < 8) begin
            @(negedge clock);
            n++;
        end
        checkOutput("fetch_latency", n, 1);
        checkOutput("instr_pc", instr_pc, exp_pc);
        checkOutput("instr", instr, mem[exp_pc]);
        checkOutput("rom_addr_hold", rom_address, exp_pc);

        for (int s = 0; s < stall; s++) begin
            instr_ready = 1'b0;
            scrambleControls();
            @(negedge clock);
            checkOutput("stall_valid", instr_valid, 1);
            checkOutput("stall_instr_pc", instr_pc, exp_pc);
            checkOutput("stall_instr", instr, mem[exp_pc]);
            checkOutput("stall_rom_addr", rom_address, exp_pc);
        end

        instr_ready = 1'b1;
        ret         = r;
        call        = c;
        redirect    = j;
        target_addr = tgt;
        @(negedge clock);
        instr_ready = 1'b0;
        scrambleControls();

        if (exp_count < 65535) exp_count++;
        code   = 0;
        new_pc = 0;
        if (r) begin
            if (ret_stack.size() == 0) code = 2;
            else new_pc = ret_stack.pop_back();
        end else if (c) begin
            if (ret_stack.size() == DEPTH) code = 1;
            else new_pc = int'(tgt);
        end else if (j) begin
            new_pc = int'(tgt);
        end else begin
            new_pc = exp_pc + 1;
        end
        if (code == 0 && new_pc > ROM_MAX) code = 3;
        if (code == 0 && !r && c) ret_stack.push_back(exp_pc + 1);

        if (code != 0) begin
            exp_fault = 1'b1;
            exp_code  = code;
            checkOutput("fault_flag", fault, 1);
            checkOutput("fault_code", fault_code, code);
            checkOutput("fault_valid", instr_valid, 0);
            checkOutput("fault_rom_addr", rom_address, exp_pc);
        end else begin
            exp_pc = new_pc;
            checkOutput("fetch_valid_low", instr_valid, 0);
            checkOutput("next_rom_addr", rom_address, exp_pc);
            checkOutput("no_fault", fault, 0);
        end
        checkOutput("fetch_count", fetch_count, expectedCount());
    endtask

    // A fault must persist, with PC frozen, until reset.
    task automatic checkFaultHold();
        instr_ready = 1'b1;
        repeat (3) begin
            scrambleControls();
            @(negedge clock);
        end
        instr_ready = 1'b0;
        checkOutput("hold_fault", fault, 1);
        checkOutput("hold_code", fault_code, exp_code);
        checkOutput("hold_valid", instr_valid, 0);
        checkOutput("hold_rom_addr", rom_address, exp_pc);
        checkOutput("hold_count", fetch_count, expectedCount());
    endtask

    initial begin
        int sel;
        logic [AW-1:0] tgt;
        for (int i = 0; i < 256; i++) mem[i] = 24'($urandom);
        mem[0] = 24'hA10D00;

        // Reset, first fetch, stall at PC 3.
        doReset();
        checkOutput("first_instr_word", 32'(mem[0]), 32'hA10D00);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 8'h00, 0);
        applyStimulus(0, 0, 0, 8'h00, 5);

        // CALL 0x0D from 0, run to 0x11, RET back to 1, then RET underflows.
        doReset();
        applyStimulus(0, 1, 0, 8'h0D, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 8'h00, 1);
        applyStimulus(1, 0, 0, 8'h00, 0);
        applyStimulus(1, 0, 0, 8'h00, 0);
        checkFaultHold();

        // RET beats CALL and redirect.
        doReset();
        applyStimulus(0, 1, 0, 8'h05, 0);
        applyStimulus(1, 1, 1, 8'h10, 0);
        applyStimulus(0, 0, 0, 8'h00, 0);

        // Nine nested calls overflow an eight-entry stack.
        doReset();
        for (int i = 0; i < 9; i++) applyStimulus(0, 1, 0, 8'(2 + i), 0);
        checkFaultHold();

        // Falling off the top of ROM, and redirecting just past it.
        doReset();
        applyStimulus(0, 0, 1, 8'h1A, 0);
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkFaultHold();
        doReset();
        applyStimulus(0, 0, 1, 8'h1B, 0);
        checkFaultHold();
        doReset();
        applyStimulus(0, 0, 1, 8'hFF, 0);
        checkFaultHold();

        // Ten plain accepts for the counter.
        doReset();
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 8'h00, 0);

        // Randomized control flow.
        doReset();
        for (int t = 0; t < 400; t++) begin
            sel = $urandom_range(0, 99);
            if ($urandom_range(0, 9) == 0) tgt = 8'($urandom_range(ROM_MAX + 1, 255));
            else tgt = 8'($urandom_range(0, ROM_MAX));
            if (sel < 15) applyStimulus(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tgt, $urandom_range(0, 3));
            else if (sel < 40) applyStimulus(0, 1, 1'($urandom_range(0, 1)), tgt, $urandom_range(0, 3));
            else if (sel < 60) applyStimulus(0, 0, 1, tgt, $urandom_range(0, 3));
            else applyStimulus(0, 0, 0, tgt, $urandom_range(0, 3));
            if (exp_fault) begin
                checkFaultHold();
                doReset();
            end else if ($urandom_range(0, 49) == 0) begin
                doReset();
            end
        end

        checkOutput("rom_addr_in_range", 32'(max_addr > ROM_MAX), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
